// File: rtl/npc_ctl_pkg.sv
// Shared definitions for the fetch-side PC sequencer: branch kind codes,
// PC reset and exception vector defaults, and instruction field widths.
package npc_ctl_pkg;

   localparam int XLEN    = 32;
   localparam int IMM_W   = 16;
   localparam int INDEX_W = 26;

   typedef logic [2:0] br_type_t;

   localparam br_type_t BR_NONE = 3'd0;
   localparam br_type_t BR_BEQ  = 3'd1;
   localparam br_type_t BR_BNE  = 3'd2;
   localparam br_type_t BR_BLEZ = 3'd3;
   localparam br_type_t BR_BGTZ = 3'd4;
   localparam br_type_t BR_BLTZ = 3'd5;
   localparam br_type_t BR_BGEZ = 3'd6;
   // j/jal and jr/jalr share this code; is_jr selects the register target
   localparam br_type_t BR_JUMP = 3'd7;

   localparam logic [XLEN-1:0] PC_RESET_DEF = 32'h0000_3000;
   localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_4180;

   function automatic logic [XLEN-1:0] br_offset(input logic [IMM_W-1:0] imm);
      return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/npc_ctl_if.sv
// ID-stage control, CP0 redirect and PC outputs of the sequencer.
// The master side drives branch/hazard/CP0 inputs; the slave is npc_ctl.
interface npc_ctl_if;
   import npc_ctl_pkg::*;

   logic                 stall;
   br_type_t             br_type;
   logic                 is_jr;
   logic                 cmp_eq;
   logic                 cmp_gtz;
   logic                 cmp_ltz;
   logic                 cmp_eqz;
   logic [IMM_W-1:0]     imm16;
   logic [INDEX_W-1:0]   instr_index;
   logic [XLEN-1:0]      rs_val;
   logic                 exc_req;
   logic                 eret_req;
   logic [XLEN-1:0]      epc;
   logic [XLEN-1:0]      pc_if;
   logic [XLEN-1:0]      pc_id;
   logic [XLEN-1:0]      link_pc;
   logic                 taken;
   logic                 bd_if;
   logic                 adel_if;

   modport master (
      output stall, br_type, is_jr, cmp_eq, cmp_gtz, cmp_ltz, cmp_eqz,
             imm16, instr_index, rs_val, exc_req, eret_req, epc,
      input  pc_if, pc_id, link_pc, taken, bd_if, adel_if
   );

   modport slave (
      input  stall, br_type, is_jr, cmp_eq, cmp_gtz, cmp_ltz, cmp_eqz,
             imm16, instr_index, rs_val, exc_req, eret_req, epc,
      output pc_if, pc_id, link_pc, taken, bd_if, adel_if
   );

endinterface

// File: rtl/npc_ctl_br_cond.sv
// Branch condition resolver: maps the ID-stage branch kind and the
// comparator flags onto a single taken decision.
module npc_ctl_br_cond
   import npc_ctl_pkg::*;
(
   input  br_type_t br_type,
   input  logic     cmp_eq,
   input  logic     cmp_gtz,
   input  logic     cmp_ltz,
   input  logic     cmp_eqz,
   output logic     taken
);

   always_comb begin
      taken = 1'b0;
      case (br_type)
         BR_BEQ:  taken = cmp_eq;
         BR_BNE:  taken = !cmp_eq;
         BR_BLEZ: taken = cmp_ltz | cmp_eqz;
         BR_BGTZ: taken = cmp_gtz;
         BR_BLTZ: taken = cmp_ltz;
         BR_BGEZ: taken = !cmp_ltz;
         BR_JUMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/npc_ctl.sv
// Fetch-side PC sequencer: owns pc_if/pc_id, resolves ID-stage branches with
// one architectural delay slot, and redirects on exception entry and eret.
module npc_ctl
   import npc_ctl_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEF,
   parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
)
(
   input  logic      clk,
   input  logic      reset,
   npc_ctl_if.slave  bus
);

   logic [XLEN-1:0] pc_if_q;
   logic [XLEN-1:0] pc_id_q;
   logic            bd_q;
   logic            adel_q;

   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] id_nxt;
   logic            bd_nxt;
   logic [XLEN-1:0] target;
   logic            taken;

   npc_ctl_br_cond u_br_cond (
      .br_type (bus.br_type),
      .cmp_eq  (bus.cmp_eq),
      .cmp_gtz (bus.cmp_gtz),
      .cmp_ltz (bus.cmp_ltz),
      .cmp_eqz (bus.cmp_eqz),
      .taken   (taken)
   );

   always_comb begin
      target = pc_id_q + 32'd4 + br_offset(bus.imm16);
      if (bus.br_type == BR_JUMP) begin
         target = bus.is_jr ? bus.rs_val : {pc_id_q[31:28], bus.instr_index, 2'b00};
      end
   end

   // The delay slot is already in IF while the branch sits in ID, so the
   // target goes straight into pc_if without any pending-redirect state.
   always_comb begin
      pc_nxt = pc_if_q + 32'd4;
      id_nxt = pc_if_q;
      bd_nxt = (bus.br_type != BR_NONE);
      if (bus.exc_req) begin
         pc_nxt = EXC_VEC;
         bd_nxt = 1'b0;
      end else if (bus.eret_req) begin
         pc_nxt = bus.epc;
         bd_nxt = 1'b0;
      end else if (bus.stall) begin
         pc_nxt = pc_if_q;
         id_nxt = pc_id_q;
         bd_nxt = bd_q;
      end else if (taken) begin
         pc_nxt = target;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_if_q <= PC_RESET;
         pc_id_q <= PC_RESET;
         bd_q    <= 1'b0;
         adel_q  <= 1'b0;
      end else begin
         pc_if_q <= pc_nxt;
         pc_id_q <= id_nxt;
         bd_q    <= bd_nxt;
         adel_q  <= (pc_nxt[1:0] != 2'b00);
      end
   end

   assign bus.pc_if   = pc_if_q;
   assign bus.pc_id   = pc_id_q;
   assign bus.bd_if   = bd_q;
   assign bus.adel_if = adel_q;
   assign bus.taken   = taken;
   assign bus.link_pc = pc_id_q + 32'd8;

endmodule

// File: tb/tb_npc_ctl.sv
// Self-checking bench for npc_ctl: directed scenarios followed by random
// stimulus, all compared against a value-level reference model.
module tb_npc_ctl;
   import npc_ctl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_if, m_id;
   logic        m_bd, m_adel;
   logic [31:0] saved_if, saved_id;

   npc_ctl_if bus ();

   npc_ctl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [2:0] bt, input logic [31:0] rs,
                                      input logic [31:0] rt);
      case (bt)
         BR_BEQ:  return rs == rt;
         BR_BNE:  return rs != rt;
         BR_BLEZ: return $signed(rs) <= 0;
         BR_BGTZ: return $signed(rs) > 0;
         BR_BLTZ: return $signed(rs) < 0;
         BR_BGEZ: return $signed(rs) >= 0;
         BR_JUMP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [2:0] bt, input logic jr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] idx,
                        input logic stl, input logic exc, input logic eret,
                        input logic [31:0] ep);
      bus.br_type     = bt;
      bus.is_jr       = jr;
      bus.rs_val      = rs;
      bus.cmp_eq      = (rs == rt);
      bus.cmp_gtz     = ($signed(rs) > 0);
      bus.cmp_ltz     = ($signed(rs) < 0);
      bus.cmp_eqz     = (rs == 32'd0);
      bus.imm16       = imm;
      bus.instr_index = idx;
      bus.stall       = stl;
      bus.exc_req     = exc;
      bus.eret_req    = eret;
      bus.epc         = ep;
   endtask

   task automatic idle();
      drive(BR_NONE, 1'b0, 32'd0, 32'd1, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic chk_regs();
      chk("pc_if", bus.pc_if, m_if);
      chk("pc_id", bus.pc_id, m_id);
      chk("bd_if", 32'(bus.bd_if), 32'(m_bd));
      chk("adel_if", 32'(bus.adel_if), 32'(m_adel));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      m_if = 32'h0000_3000; m_id = 32'h0000_3000; m_bd = 1'b0; m_adel = 1'b0;
      chk_regs();
      reset = 1'b1;
   endtask

   task automatic step(input logic [2:0] bt, input logic jr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] idx,
                       input logic stl, input logic exc, input logic eret,
                       input logic [31:0] ep);
      logic        tk;
      logic [31:0] tgt;
      @(negedge clk);
      drive(bt, jr, rs, rt, imm, idx, stl, exc, eret, ep);
      #1;
      tk = ref_taken(bt, rs, rt);
      chk("taken", 32'(bus.taken), 32'(tk));
      chk("link_pc", bus.link_pc, m_id + 32'd8);
      if (bt == BR_JUMP)
         tgt = jr ? rs : {m_id[31:28], idx, 2'b00};
      else
         tgt = m_id + 32'd4 + 32'($signed(imm)) * 32'd4;
      if (exc) begin
         m_id = m_if; m_if = 32'h0000_4180; m_bd = 1'b0;
      end else if (eret) begin
         m_id = m_if; m_if = ep; m_bd = 1'b0;
      end else if (!stl) begin
         m_id = m_if;
         m_if = tk ? tgt : m_if + 32'd4;
         m_bd = (bt != BR_NONE);
      end
      m_adel = (m_if % 4) != 0;
      @(posedge clk);
      #1;
      chk_regs();
   endtask

   task automatic plain();
      step(BR_NONE, 1'b0, 32'd0, 32'd1, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] r_rs, r_rt;
      reset = 1'b1;
      idle();

      // reset release and sequential fetch
      do_reset(2);
      chk("rst_pc_if", bus.pc_if, 32'h0000_3000);
      plain();
      chk("seq_pc_if1", bus.pc_if, 32'h0000_3004);
      plain();
      chk("seq_pc_if2", bus.pc_if, 32'h0000_3008);

      // BEQ taken backward from 0x3010
      for (int i = 0; i < 16 && m_id != 32'h0000_3010; i++) plain();
      chk("beq_pc_id", bus.pc_id, 32'h0000_3010);
      chk("beq_slot", bus.pc_if, 32'h0000_3014);
      step(BR_BEQ, 1'b0, 32'd5, 32'd5, 16'hFFFC, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("beq_target", bus.pc_if, 32'h0000_3004);
      chk("beq_bd", 32'(bus.bd_if), 32'd1);
      plain();
      chk("beq_bd_clr", 32'(bus.bd_if), 32'd0);

      // BGEZ/BLEZ at zero and BLEZ on positive
      step(BR_BGEZ, 1'b0, 32'd0, 32'd9, 16'h0010, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(BR_BLEZ, 1'b0, 32'd0, 32'd9, 16'h0020, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      saved_if = bus.pc_if;
      step(BR_BLEZ, 1'b0, 32'd5, 32'd9, 16'h0020, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("blez_nt", bus.pc_if, saved_if + 32'd4);
      chk("blez_nt_bd", 32'(bus.bd_if), 32'd1);

      // misaligned jr target is fetched and flagged
      step(BR_JUMP, 1'b1, 32'h0000_3102, 32'd0, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("jr_pc_if", bus.pc_if, 32'h0000_3102);
      chk("jr_adel", 32'(bus.adel_if), 32'd1);
      plain();

      // jal link value and target
      do_reset(1);
      for (int i = 0; i < 16 && m_id != 32'h0000_3020; i++) plain();
      chk("jal_link", bus.link_pc, 32'h0000_3028);
      step(BR_JUMP, 1'b0, 32'd0, 32'd0, 16'd0, 26'h000_0C10, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("jal_target", bus.pc_if, 32'h0000_3040);

      // stall with a taken branch in ID, redirect once stall drops
      saved_if = bus.pc_if;
      saved_id = bus.pc_id;
      for (int i = 0; i < 3; i++) begin
         step(BR_BNE, 1'b0, 32'd1, 32'd2, 16'h0004, 26'd0, 1'b1, 1'b0, 1'b0, 32'd0);
         chk("stall_if", bus.pc_if, saved_if);
         chk("stall_id", bus.pc_id, saved_id);
      end
      step(BR_BNE, 1'b0, 32'd1, 32'd2, 16'h0004, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("stall_redir", bus.pc_if, saved_id + 32'd4 + 32'd16);

      // exception beats eret and stall, then eret returns to epc
      step(BR_BEQ, 1'b0, 32'd3, 32'd3, 16'h0008, 26'd0, 1'b1, 1'b1, 1'b1, 32'h0000_3040);
      chk("exc_vec", bus.pc_if, 32'h0000_4180);
      chk("exc_bd", 32'(bus.bd_if), 32'd0);
      step(BR_NONE, 1'b0, 32'd0, 32'd1, 16'd0, 26'd0, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
      chk("eret_pc", bus.pc_if, 32'h0000_3040);

      // reset during a taken branch discards the redirect
      @(negedge clk);
      drive(BR_BEQ, 1'b0, 32'd7, 32'd7, 16'h0100, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      do_reset(1);
      plain();
      chk("rst_mid_br", bus.pc_if, 32'h0000_3004);

      // random stimulus
      for (int n = 0; n < 400; n++) begin
         r_rt = (($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom);
         case ($urandom_range(0, 4))
            0: r_rs = 32'd0;
            1: r_rs = 32'hFFFF_FFFF;
            2: r_rs = r_rt;
            3: r_rs = $urandom_range(1, 100);
            default: r_rs = $urandom;
         endcase
         if ($urandom_range(0, 99) == 0) begin
            @(negedge clk);
            drive(3'($urandom_range(0, 7)), 1'($urandom), r_rs, r_rt, 16'($urandom),
                  26'($urandom), 1'b0, 1'b0, 1'b0, 32'd0);
            do_reset(1);
         end else begin
            step(3'($urandom_range(0, 7)), 1'($urandom), r_rs, r_rt, 16'($urandom),
                 26'($urandom), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 4, ($urandom_range(0, 3) == 0) ? $urandom
                 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
